// File: rtl/packet_stream_arbiter.sv
// Round-robin packet arbiter: feeds one shared decoder from NUM_PORTS word streams,
// one whole packet per grant, and tags each decoded packet with its source port.
module packet_stream_arbiter #(
  parameter int unsigned NUM_PORTS        = 4,
  parameter int unsigned PORT_W           = 2,
  parameter int unsigned WORDS_PER_PACKET = 2,
  parameter int unsigned DECODE_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [64*NUM_PORTS-1:0]   req_data,
  output logic [NUM_PORTS-1:0]      req_pop,
  output logic [63:0]               dec_data,
  output logic                      dec_push,
  output logic [PORT_W-1:0]         tag_src,
  output logic                      tag_valid,
  output logic                      busy
);

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned CNT_W     = $clog2(WORDS_PER_PACKET + 1);
  localparam int unsigned TAG_DEPTH = 1 + DECODE_LATENCY;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state, state_d;
  logic [PORT_W-1:0]      gnt, gnt_d;
  logic [PORT_W-1:0]      rr_ptr, rr_ptr_d;
  logic [PORT_W-1:0]      sel, pop_port;
  logic [CNT_W-1:0]       word_cnt, word_cnt_d;
  logic                   sel_found, pop, last_pop;
  logic [TAG_DEPTH-1:0]   tag_v;
  logic [PORT_W-1:0]      tag_s [TAG_DEPTH];
  logic [DATA_W-1:0]      words [NUM_PORTS];

  for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_words
    assign words[i] = req_data[DATA_W*i +: DATA_W];
  end

  // First valid port at or after rr_ptr, wrapping upward.
  always_comb begin
    int unsigned idx;
    logic [PORT_W-1:0] pidx;
    sel       = rr_ptr;
    sel_found = 1'b0;
    idx       = 0;
    pidx      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      pidx = PORT_W'(idx);
      if (!sel_found && req_valid[pidx]) begin
        sel_found = 1'b1;
        sel       = pidx;
      end
    end
  end

  // Next state, grant bookkeeping and the combinational pop.
  // tag_v[0] marks the cycle right after a last pop: that cycle is the
  // mandatory gap that lets the decoder drain before the next packet starts.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    rr_ptr_d   = rr_ptr;
    word_cnt_d = word_cnt;
    req_pop    = '0;
    pop        = 1'b0;
    last_pop   = 1'b0;
    pop_port   = gnt;
    unique case (state)
      IDLE: begin
        if (enable && sel_found && !tag_v[0]) begin
          gnt_d    = sel;
          pop_port = sel;
          pop      = 1'b1;
          rr_ptr_d = (sel == PORT_W'(NUM_PORTS - 1)) ? '0 : sel + PORT_W'(1);
          if (WORDS_PER_PACKET == 1) begin
            last_pop   = 1'b1;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = CNT_W'(1);
            state_d    = GRANT;
          end
        end
      end
      GRANT: begin
        if (req_valid[gnt]) begin
          pop = 1'b1;
          if (word_cnt == CNT_W'(WORDS_PER_PACKET - 1)) begin
            last_pop   = 1'b1;
            word_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop && !reset) req_pop[pop_port] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
      dec_data <= '0;
      dec_push <= 1'b0;
      tag_v    <= '0;
      for (int i = 0; i < int'(TAG_DEPTH); i++) tag_s[i] <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      rr_ptr   <= rr_ptr_d;
      word_cnt <= word_cnt_d;
      dec_push <= pop;
      if (pop) dec_data <= words[pop_port];
      tag_v[0] <= last_pop;
      tag_s[0] <= last_pop ? pop_port : '0;
      for (int i = 1; i < int'(TAG_DEPTH); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end
    end
  end

  assign tag_valid = tag_v[TAG_DEPTH-1];
  assign tag_src   = tag_s[TAG_DEPTH-1];
  assign busy      = (state == GRANT) | dec_push | (|tag_v);

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Directed bench for packet_stream_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later, expectations hand-computed per cycle.
module tb_packet_stream_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    req_valid;
  logic [255:0]  req_data;
  logic [3:0]    req_pop;
  logic [63:0]   dec_data;
  logic          dec_push;
  logic [1:0]    tag_src;
  logic          tag_valid;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  packet_stream_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_pop(req_pop),
    .dec_data(dec_data), .dec_push(dec_push),
    .tag_src(tag_src), .tag_valid(tag_valid), .busy(busy)
  );

  // All ports valid: 2 pops then 1 gap per packet, grant order 0,1,2,3,0,1.
  logic [3:0] rr_pop [18] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                              4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0};
  int         rr_tag [18] = '{-1, -1, -1, -1, 0, -1, -1, 1, -1,
                              -1, 2, -1, -1, 3, -1, -1, 0, -1};

  function automatic logic [63:0] word_of(input int p);
    return 64'h1111_1111_1111_1111 * 64'(p + 1);
  endfunction

  function automatic int port_of(input logic [3:0] oh);
    return oh[1] ? 1 : oh[2] ? 2 : oh[3] ? 3 : 0;
  endfunction

  task automatic set_word(input int p, input logic [63:0] v);
    req_data[64*p +: 64] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; req_valid = 4'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; req_valid = 4'hF;
    #1;
    total++; if (req_pop !== 4'h0) begin bad++; $display("FAIL reset_pop got=%b exp=0000", req_pop); end
    @(negedge clk); #1;
    total++; if (dec_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", dec_push); end
    total++; if (dec_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dec_data); end
    total++; if (tag_valid !== 1'b0) begin bad++; $display("FAIL reset_tagv got=%b exp=0", tag_valid); end
    total++; if (tag_src !== 2'd0) begin bad++; $display("FAIL reset_tags got=%0d exp=0", tag_src); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    enable = 1'b0; req_valid = 4'h0;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_word(2, word_of(2));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin enable = 1'b1; req_valid = 4'h4; end
      if (c == 1) reset = 1'b1;
      if (c == 2) reset = 1'b0;
      if (c == 4) req_valid = 4'h0;
      #1;
      if (c == 1) begin
        total++; if (dec_push !== 1'b0 || busy !== 1'b0 || req_pop !== 4'h0)
          begin bad++; $display("FAIL midrst_drop push=%b busy=%b pop=%b exp=0,0,0000", dec_push, busy, req_pop); end
      end
      if (c == 0 || c == 2 || c == 3) begin
        total++; if (req_pop !== 4'h4) begin bad++; $display("FAIL midrst_pop c=%0d got=%b exp=0100", c, req_pop); end
      end
      if (c >= 2) begin
        total++; if (tag_valid !== (c == 6)) begin bad++; $display("FAIL midrst_tagv c=%0d got=%b exp=%b", c, tag_valid, c == 6); end
      end
      if (c == 6) begin
        total++; if (tag_src !== 2'd2) begin bad++; $display("FAIL midrst_tags got=%0d exp=2", tag_src); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_single_stream();
    logic [63:0] wa, wb;
    wa = 64'hAAAA_0000_1234_5678;
    wb = 64'hBBBB_0000_8765_4321;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin enable = 1'b1; req_valid = 4'h2; set_word(1, wa); end
      if (c == 1) set_word(1, wb);
      if (c == 2) req_valid = 4'h0;
      #1;
      total++; if (req_pop !== ((c < 2) ? 4'h2 : 4'h0)) begin bad++; $display("FAIL single_pop c=%0d got=%b", c, req_pop); end
      total++; if (dec_push !== (c == 1 || c == 2)) begin bad++; $display("FAIL single_push c=%0d got=%b", c, dec_push); end
      if (c == 1 || c == 2) begin
        total++; if (dec_data !== ((c == 1) ? wa : wb)) begin bad++; $display("FAIL single_data c=%0d got=%h", c, dec_data); end
      end
      total++; if (tag_valid !== (c == 4)) begin bad++; $display("FAIL single_tagv c=%0d got=%b exp=%b", c, tag_valid, c == 4); end
      if (c == 4) begin
        total++; if (tag_src !== 2'd1) begin bad++; $display("FAIL single_tags got=%0d exp=1", tag_src); end
      end
      if (c == 5) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] prev;
    do_reset();
    for (int p = 0; p < 4; p++) set_word(p, word_of(p));
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) begin enable = 1'b1; req_valid = 4'hF; end
      #1;
      prev = (c > 0) ? rr_pop[c-1] : 4'h0;
      total++; if (req_pop !== rr_pop[c]) begin bad++; $display("FAIL rr_pop c=%0d got=%b exp=%b", c, req_pop, rr_pop[c]); end
      total++; if (dec_push !== (prev != 4'h0)) begin bad++; $display("FAIL rr_push c=%0d got=%b", c, dec_push); end
      if (prev != 4'h0) begin
        total++; if (dec_data !== word_of(port_of(prev))) begin bad++; $display("FAIL rr_data c=%0d got=%h", c, dec_data); end
      end
      total++; if (tag_valid !== (rr_tag[c] >= 0)) begin bad++; $display("FAIL rr_tagv c=%0d got=%b", c, tag_valid); end
      if (rr_tag[c] >= 0) begin
        total++; if (tag_src !== 2'(rr_tag[c])) begin bad++; $display("FAIL rr_tags c=%0d got=%0d exp=%0d", c, tag_src, rr_tag[c]); end
      end
    end
    enable = 1'b0; req_valid = 4'h0;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_pop [9] = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [63:0] w3a, w3b;
    w3a = 64'h3333_AAAA_0000_0001;
    w3b = 64'h3333_BBBB_0000_0002;
    do_reset();
    set_word(0, word_of(0));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      enable = 1'b1;
      req_valid = (c == 0) ? 4'h8 : (c <= 5) ? 4'h1 : 4'h9;
      set_word(3, (c == 0) ? w3a : w3b);
      #1;
      total++; if (req_pop !== exp_pop[c]) begin bad++; $display("FAIL starve_pop c=%0d got=%b exp=%b", c, req_pop, exp_pop[c]); end
      total++; if (dec_push !== (c == 1 || c == 7)) begin bad++; $display("FAIL starve_push c=%0d got=%b", c, dec_push); end
      if (c == 1 || c == 7) begin
        total++; if (dec_data !== ((c == 1) ? w3a : w3b)) begin bad++; $display("FAIL starve_data c=%0d got=%h", c, dec_data); end
      end
      if (c >= 1) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL starve_busy c=%0d got=%b exp=1", c, busy); end
      end
    end
    enable = 1'b0; req_valid = 4'h0;
  endtask

  task automatic test_enable();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
      enable = (c == 4);
      #1;
      total++; if (req_pop !== ((c == 4 || c == 5) ? 4'h1 : 4'h0)) begin bad++; $display("FAIL en_pop c=%0d got=%b", c, req_pop); end
      if (c < 4 || c == 9) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy c=%0d got=%b exp=0", c, busy); end
      end
      if (c == 8) begin
        total++; if (tag_valid !== 1'b1 || tag_src !== 2'd0) begin bad++; $display("FAIL en_tag got=%b/%0d exp=1/0", tag_valid, tag_src); end
      end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pop [7] = '{4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      enable = 1'b1;
      req_valid = (c < 2) ? 4'h4 : (c < 5) ? 4'h1 : 4'hF;
      #1;
      total++; if (req_pop !== exp_pop[c]) begin bad++; $display("FAIL wrap_pop c=%0d got=%b exp=%b", c, req_pop, exp_pop[c]); end
    end
    enable = 1'b0; req_valid = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = 4'h0; req_data = '0;
    test_reset();
    test_reset_mid_packet();
    test_single_stream();
    test_round_robin();
    test_starvation();
    test_enable();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
